// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift register and its command sequencer.
// The register decodes the same mode-select constants that the controller drives.
package usr_pkg;

    localparam logic [1:0] USR_OP_LOAD = 2'd0;
    localparam logic [1:0] USR_OP_UP   = 2'd1;
    localparam logic [1:0] USR_OP_DOWN = 2'd2;
    localparam logic [1:0] USR_OP_RSVD = 2'd3;

    localparam logic [2:0] USR_S_HOLD = 3'b000;
    localparam logic [2:0] USR_S_UP   = 3'b001;
    localparam logic [2:0] USR_S_DOWN = 3'b010;
    localparam logic [2:0] USR_S_LOAD = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } usr_state_t;

    // Mode select that performs one step of the given shift direction.
    function automatic logic [2:0] usr_shift_sel(input logic down);
        return down ? USR_S_DOWN : USR_S_UP;
    endfunction

endpackage

// File: rtl/usr_shift_ctrl.sv
// Command sequencer for a universal shift register: turns load/shift/rotate
// commands into per-cycle mode selects and pulses done (and err) on completion.
module usr_shift_ctrl
    import usr_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic             cmd_rot,
    input  logic             cmd_fill,
    input  logic [AMT_W-1:0] cmd_amt,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [WIDTH-1:0] usr_q,
    output logic [2:0]       usr_s,
    output logic [WIDTH-1:0] usr_i,
    output logic             usr_left,
    output logic             usr_right,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [AMT_W:0]   MAX_AMT = (AMT_W + 1)'(WIDTH);
    localparam logic [AMT_W-1:0] ONE     = AMT_W'(1);

    usr_state_t       state_reg, state_next;
    logic [AMT_W-1:0] count_reg, count_next;
    logic             dir_reg, dir_next;   // 1 = down (toward LSB)
    logic             rot_reg, rot_next;
    logic             fill_reg, fill_next;
    logic             err_reg, err_next;
    logic [2:0]       usr_s_reg, usr_s_next;
    logic [WIDTH-1:0] usr_i_reg, usr_i_next;

    logic amt_too_big;
    assign amt_too_big = ({1'b0, cmd_amt} > MAX_AMT);

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        dir_next   = dir_reg;
        rot_next   = rot_reg;
        fill_next  = fill_reg;
        err_next   = 1'b0;
        usr_s_next = USR_S_HOLD;
        usr_i_next = usr_i_reg;

        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid) begin
                    dir_next   = (cmd_op == USR_OP_DOWN);
                    rot_next   = cmd_rot;
                    fill_next  = cmd_fill;
                    count_next = cmd_amt;
                    if (cmd_op == USR_OP_LOAD) begin
                        state_next = ST_LOAD;
                        usr_s_next = USR_S_LOAD;
                        usr_i_next = cmd_data;
                    end else if (cmd_op == USR_OP_RSVD || amt_too_big) begin
                        state_next = ST_DONE;
                        err_next   = 1'b1;
                    end else if (cmd_amt == '0) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_SHIFT;
                        usr_s_next = usr_shift_sel(cmd_op == USR_OP_DOWN);
                    end
                end
            end
            ST_LOAD: begin
                state_next = ST_DONE;
            end
            ST_SHIFT: begin
                // The count says how many shift cycles remain including this one.
                if (count_reg == ONE) begin
                    state_next = ST_DONE;
                end else begin
                    count_next = count_reg - ONE;
                    usr_s_next = usr_shift_sel(dir_reg);
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
            dir_reg   <= 1'b0;
            rot_reg   <= 1'b0;
            fill_reg  <= 1'b0;
            err_reg   <= 1'b0;
            usr_s_reg <= USR_S_HOLD;
            usr_i_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            dir_reg   <= dir_next;
            rot_reg   <= rot_next;
            fill_reg  <= fill_next;
            err_reg   <= err_next;
            usr_s_reg <= usr_s_next;
            usr_i_reg <= usr_i_next;
        end
    end

    // Serial inputs follow the live register output so rotates see current contents.
    always_comb begin
        usr_left  = 1'b0;
        usr_right = 1'b0;
        if (dir_reg) begin
            usr_right = rot_reg ? usr_q[0] : fill_reg;
        end else begin
            usr_left = rot_reg ? usr_q[WIDTH-1] : fill_reg;
        end
    end

    assign cmd_ready = (state_reg == ST_IDLE);
    assign busy      = (state_reg != ST_IDLE);
    assign done      = (state_reg == ST_DONE);
    assign err       = err_reg;
    assign usr_s     = usr_s_reg;
    assign usr_i     = usr_i_reg;

endmodule

// File: tb/tb_usr_shift_ctrl.sv
// Bench for usr_shift_ctrl driving a 4-bit universal shift register; directed
// table, randomized commands against an arithmetic model, and multi-cycle corners.
module tb_usr_shift_ctrl;
    import usr_pkg::*;

    logic       clk = 1'b0;
    logic       clear;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic       cmd_rot;
    logic       cmd_fill;
    logic [2:0] cmd_amt;
    logic [3:0] cmd_data;
    logic [3:0] usr_q;
    logic [2:0] usr_s;
    logic [3:0] usr_i;
    logic       usr_left;
    logic       usr_right;
    logic       busy;
    logic       done;
    logic       err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    usr_shift_ctrl #(.WIDTH(4), .AMT_W(3)) dut (
        .clk      (clk),
        .clear    (clear),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_rot  (cmd_rot),
        .cmd_fill (cmd_fill),
        .cmd_amt  (cmd_amt),
        .cmd_data (cmd_data),
        .usr_q    (usr_q),
        .usr_s    (usr_s),
        .usr_i    (usr_i),
        .usr_left (usr_left),
        .usr_right(usr_right),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    // The downstream universal shift register, sharing clk and clear.
    logic [3:0] q_reg;
    always_ff @(posedge clk) begin
        if (clear) q_reg <= 4'b0000;
        else begin
            case (usr_s)
                USR_S_UP:   q_reg <= {q_reg[2:0], usr_left};
                USR_S_DOWN: q_reg <= {usr_right, q_reg[3:1]};
                USR_S_LOAD: q_reg <= usr_i;
                default:    q_reg <= q_reg;
            endcase
        end
    end
    assign usr_q = q_reg;

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Reference: whole-command effect on the register value, plus timing.
    function automatic void ref_cmd(input logic [1:0] op, input logic rot, input logic fill,
                                    input int amt, input logic [3:0] data, input logic [3:0] q_in,
                                    output logic [3:0] q_out, output int lat, output logic e,
                                    output int act);
        int v;
        int fm;
        v = int'(q_in);
        q_out = q_in;
        e = 1'b0;
        if (op == 2'd0) begin
            q_out = data; lat = 2; act = 1;
        end else if (op == 2'd3 || amt > 4) begin
            lat = 1; act = 0; e = 1'b1;
        end else if (amt == 0) begin
            lat = 1; act = 0;
        end else begin
            lat = amt + 1; act = amt;
            fm = fill ? ((1 << amt) - 1) : 0;
            if (op == 2'd1) v = rot ? ((v << amt) | (v >> (4 - amt))) : ((v << amt) | fm);
            else            v = rot ? ((v >> amt) | (v << (4 - amt))) : ((v >> amt) | (fm << (4 - amt)));
            q_out = 4'(v & 15);
        end
    endfunction

    // Issue one command (caller is at a negedge) and observe it until done.
    task automatic run_cmd(input logic [1:0] op, input logic rot, input logic fill,
                           input logic [2:0] amt, input logic [3:0] data,
                           output int lat, output logic e, output logic [3:0] q,
                           output int act, output int bad_s, output logic [1:0] ser1,
                           output logic rdy1, output int err_stray);
        int w;
        logic [2:0] exp_s;
        w = 0;
        while (!cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) chk("ready_timeout", 0, 1);
        exp_s = (op == 2'd0) ? USR_S_LOAD : ((op == 2'd2) ? USR_S_DOWN : USR_S_UP);
        cmd_valid = 1'b1; cmd_op = op; cmd_rot = rot; cmd_fill = fill;
        cmd_amt = amt; cmd_data = data;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom); cmd_rot = 1'($urandom); cmd_fill = 1'($urandom);
        cmd_amt = 3'($urandom); cmd_data = 4'($urandom);
        lat = -1; act = 0; bad_s = 0; err_stray = 0; e = 1'b0; q = q_reg;
        rdy1 = cmd_ready;
        ser1 = {usr_left, usr_right};
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) @(negedge clk);
            if (usr_s != USR_S_HOLD) begin
                act++;
                if (usr_s != exp_s) bad_s++;
            end
            if (err && !done) err_stray++;
            if (done) begin
                lat = c; e = err; q = q_reg;
                break;
            end
        end
    endtask

    typedef struct {
        logic [1:0] op;
        logic       rot;
        logic       fill;
        logic [2:0] amt;
        logic [3:0] data;
        logic [3:0] exp_q;
        int         exp_lat;
        logic       exp_err;
        int         exp_act;
        logic       chk_ser;
        logic [1:0] exp_ser;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int lat, act, bad_s, err_stray, accepts, first, second, dones, w;
        logic e, rdy1;
        logic [3:0] q, mq, mq_next;
        logic [1:0] ser1;
        logic [1:0] rop;
        logic [2:0] ramt;
        logic rrot, rfill;
        logic [3:0] rdata;
        int elat, eact;
        logic eerr;

        vecs[0] = '{2'd0, 1'b0, 1'b0, 3'd0, 4'b1010, 4'b1010, 2, 1'b0, 1, 1'b0, 2'b00};
        vecs[1] = '{2'd1, 1'b0, 1'b1, 3'd2, 4'b0000, 4'b1011, 3, 1'b0, 2, 1'b1, 2'b10};
        vecs[2] = '{2'd2, 1'b1, 1'b0, 3'd1, 4'b0000, 4'b1101, 2, 1'b0, 1, 1'b1, 2'b01};
        vecs[3] = '{2'd1, 1'b1, 1'b0, 3'd4, 4'b0000, 4'b1101, 5, 1'b0, 4, 1'b0, 2'b00};
        vecs[4] = '{2'd2, 1'b0, 1'b1, 3'd5, 4'b0000, 4'b1101, 1, 1'b1, 0, 1'b0, 2'b00};
        vecs[5] = '{2'd3, 1'b0, 1'b0, 3'd2, 4'b0000, 4'b1101, 1, 1'b1, 0, 1'b0, 2'b00};
        vecs[6] = '{2'd1, 1'b0, 1'b1, 3'd0, 4'b0000, 4'b1101, 1, 1'b0, 0, 1'b0, 2'b00};
        vecs[7] = '{2'd2, 1'b0, 1'b0, 3'd4, 4'b0000, 4'b0000, 5, 1'b0, 4, 1'b0, 2'b00};

        clear = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_rot = 1'b0;
        cmd_fill = 1'b0; cmd_amt = 3'd0; cmd_data = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_usr_s", int'(usr_s), 0);
        chk("rst_usr_i", int'(usr_i), 0);
        chk("rst_serial", int'({usr_left, usr_right}), 0);
        clear = 1'b0;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 8; i++) begin
            run_cmd(vecs[i].op, vecs[i].rot, vecs[i].fill, vecs[i].amt, vecs[i].data,
                    lat, e, q, act, bad_s, ser1, rdy1, err_stray);
            $display("vec %0d op=%0d amt=%0d rot=%0d fill=%0d -> lat=%0d err=%0d q=%b",
                     i, vecs[i].op, vecs[i].amt, vecs[i].rot, vecs[i].fill, lat, e, q);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("vec%0d_err", i), int'(e), int'(vecs[i].exp_err));
            chk($sformatf("vec%0d_usr_q", i), int'(q), int'(vecs[i].exp_q));
            chk($sformatf("vec%0d_active_cycles", i), act, vecs[i].exp_act);
            chk($sformatf("vec%0d_bad_usr_s", i), bad_s, 0);
            chk($sformatf("vec%0d_ready_k1", i), int'(rdy1), 0);
            chk($sformatf("vec%0d_err_outside_done", i), err_stray, 0);
            if (vecs[i].chk_ser)
                chk($sformatf("vec%0d_serial_pins", i), int'(ser1), int'(vecs[i].exp_ser));
        end

        // cmd_valid held high: one acceptance per visit to IDLE
        w = 0;
        while (!cmd_ready && w < 50) begin @(negedge clk); w++; end
        cmd_valid = 1'b1; cmd_op = USR_OP_UP; cmd_rot = 1'b1; cmd_fill = 1'b0;
        cmd_amt = 3'd2; cmd_data = 4'd0;
        accepts = 0; first = -1; second = -1;
        for (int c = 0; c < 12; c++) begin
            if (cmd_ready) begin
                accepts++;
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
            @(posedge clk);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        $display("held-valid: accepts=%0d first=%0d second=%0d", accepts, first, second);
        chk("held_valid_accepts", accepts, 3);
        chk("held_valid_spacing", second - first, 4);
        w = 0;
        while (!cmd_ready && w < 50) begin @(negedge clk); w++; end
        chk("held_valid_drain", int'(cmd_ready), 1);

        // Randomized commands against the model; first one is a LOAD to seed it
        mq = 4'd0;
        for (int i = 0; i < 40; i++) begin
            rop = (i == 0) ? 2'd0 : 2'($urandom_range(0, 3));
            ramt = 3'($urandom_range(0, 7));
            rrot = 1'($urandom); rfill = 1'($urandom); rdata = 4'($urandom);
            ref_cmd(rop, rrot, rfill, int'(ramt), rdata, mq, mq_next, elat, eerr, eact);
            run_cmd(rop, rrot, rfill, ramt, rdata, lat, e, q, act, bad_s, ser1, rdy1, err_stray);
            $display("rnd %0d op=%0d amt=%0d rot=%0d fill=%0d data=%b -> lat=%0d err=%0d q=%b",
                     i, rop, ramt, rrot, rfill, rdata, lat, e, q);
            chk($sformatf("rnd%0d_latency", i), lat, elat);
            chk($sformatf("rnd%0d_err", i), int'(e), int'(eerr));
            chk($sformatf("rnd%0d_usr_q", i), int'(q), int'(mq_next));
            chk($sformatf("rnd%0d_active_cycles", i), act, eact);
            chk($sformatf("rnd%0d_bad_usr_s", i), bad_s, 0);
            mq = mq_next;
        end

        // clear in the second cycle of a SHIFT_UP amt=4
        run_cmd(2'd0, 1'b0, 1'b0, 3'd0, 4'b0110, lat, e, q, act, bad_s, ser1, rdy1, err_stray);
        chk("abort_preload_q", int'(q), 6);
        w = 0;
        while (!cmd_ready && w < 50) begin @(negedge clk); w++; end
        cmd_valid = 1'b1; cmd_op = USR_OP_UP; cmd_rot = 1'b1; cmd_fill = 1'b1;
        cmd_amt = 3'd4; cmd_data = 4'd0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        $display("abort: ready=%0d busy=%0d usr_s=%b q=%b done=%0d", cmd_ready, busy, usr_s, usr_q, done);
        chk("abort_ready", int'(cmd_ready), 1);
        chk("abort_busy", int'(busy), 0);
        chk("abort_usr_s", int'(usr_s), 0);
        chk("abort_usr_q", int'(usr_q), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_err", int'(err), 0);
        dones = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done || err) dones++;
        end
        chk("abort_no_done_pulse", dones, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
